// File: rtl/grid_move_ctrl.sv
// grid_move_ctrl: 4x4 2048 board; slides/merges one line per LOAD/MERGE/STORE pass, then spawns a tile.
// Optional GRID_SCORE_EN adds a saturating score output.
module grid_move_ctrl #(
  parameter int WIN_EXP = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dir,
  output logic       cmd_ready,
  input  logic       new_game,
  input  logic       wr_en,
  input  logic [1:0] wr_x,
  input  logic [1:0] wr_y,
  input  logic [5:0] wr_val,
  input  logic [1:0] rd_x,
  input  logic [1:0] rd_y,
  output logic [5:0] rd_val,
  output logic       busy,
  output logic       done,
  output logic       moved,
  output logic       win,
  output logic       lose
`ifdef GRID_SCORE_EN
  ,
  output logic [19:0] score
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, MERGE, STORE, SPAWN, DONE} state_t;
  state_t state;
  logic [5:0] board [16];
  logic [5:0] b [4];
  logic [5:0] c [5];
  logic [5:0] o [4];
  logic [1:0] dir, l, spn, n, m;
  logic [15:0] lfsr;
  logic [3:0] sp;
  logic ng, skip, mwin, found, full, pair;
`ifdef GRID_SCORE_EN
  logic [21:0] add, add_q;
  logic [22:0] sum;
  assign sum = {3'd0, score} + {1'b0, add_q};
`endif
  // element k of line ln in direction d; right/down walk the line backwards
  function automatic logic [3:0] idx(input logic [1:0] d, ln, k);
    return d[1] ? {(d[0] ? ~k : k), ln} : {ln, (d[0] ? ~k : k)};
  endfunction
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign rd_val = board[{rd_y, rd_x}];
  always_comb begin
    for (int k = 0; k < 5; k++) c[k] = '0;
    for (int k = 0; k < 4; k++) o[k] = '0;
    n = '0;
    m = '0;
    skip = 1'b0;
    mwin = 1'b0;
`ifdef GRID_SCORE_EN
    add = '0;
`endif
    for (int k = 0; k < 4; k++)
      if (b[k] != '0) begin
        c[n] = b[k];
        n = n + 2'd1;
      end
    // skip marks the partner of a merged tile so it cannot merge again
    for (int k = 0; k < 4; k++)
      if (skip) skip = 1'b0;
      else if (c[k] != '0) begin
        skip = c[k] == c[k+1];
        o[m] = skip ? (c[k] == 6'd63 ? c[k] : c[k] + 6'd1) : c[k];
        mwin = mwin | (skip && o[m] >= 6'(WIN_EXP));
`ifdef GRID_SCORE_EN
        add = add + (skip ? (o[m] > 6'd19 ? 22'h100000 : 22'd1 << o[m]) : 22'd0);
`endif
        m = m + 2'd1;
      end
  end
  always_comb begin
    found = 1'b0;
    sp = '0;
    for (int i = 15; i >= 0; i--)
      if (board[lfsr[3:0] + 4'(i)] == '0) begin
        found = 1'b1;
        sp = lfsr[3:0] + 4'(i);
      end
  end
  always_comb begin
    full = 1'b1;
    pair = 1'b0;
    for (int i = 0; i < 16; i++) full = full & (board[i] != '0);
    for (int i = 0; i < 15; i++) pair = pair | (i % 4 != 3 && board[i] == board[i+1]);
    for (int i = 0; i < 12; i++) pair = pair | (board[i] == board[i+4]);
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      lfsr <= LFSR_SEED;
      dir <= '0;
      l <= '0;
      spn <= '0;
      ng <= 1'b0;
      done <= 1'b0;
      moved <= 1'b0;
      win <= 1'b0;
      lose <= 1'b0;
      for (int i = 0; i < 16; i++) board[i] <= '0;
      for (int k = 0; k < 4; k++) b[k] <= '0;
`ifdef GRID_SCORE_EN
      score <= '0;
      add_q <= '0;
`endif
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
      done <= 1'b0;
      case (state)
        IDLE:
          if (new_game) begin
            win <= 1'b0;
            moved <= 1'b0;
            lose <= 1'b0;
            ng <= 1'b1;
            spn <= 2'd3;
            state <= SPAWN;
`ifdef GRID_SCORE_EN
            score <= '0;
`endif
          end else if (cmd_valid) begin
            dir <= cmd_dir;
            moved <= 1'b0;
            ng <= 1'b0;
            l <= '0;
            state <= LOAD;
          end else if (wr_en) board[{wr_y, wr_x}] <= wr_val;
        LOAD: begin
          for (int k = 0; k < 4; k++) b[k] <= board[idx(dir, l, 2'(k))];
          state <= MERGE;
        end
        MERGE: begin
          b <= o;
          win <= win | mwin;
`ifdef GRID_SCORE_EN
          add_q <= add;
`endif
          state <= STORE;
        end
        STORE: begin
          for (int k = 0; k < 4; k++) begin
            board[idx(dir, l, 2'(k))] <= b[k];
            if (b[k] != board[idx(dir, l, 2'(k))]) moved <= 1'b1;
          end
`ifdef GRID_SCORE_EN
          score <= sum > 23'hFFFFF ? 20'hFFFFF : sum[19:0];
`endif
          l <= l + 2'd1;
          spn <= 2'd1;
          state <= l == 2'd3 ? SPAWN : LOAD;
        end
        SPAWN: begin
          // new_game spends its first SPAWN cycle clearing, then spawns twice
          if (spn == 2'd3) for (int i = 0; i < 16; i++) board[i] <= '0;
          else if ((ng || moved) && found) board[sp] <= 6'd1;
          spn <= spn - 2'd1;
          state <= spn == 2'd1 ? DONE : SPAWN;
        end
        DONE: begin
          done <= 1'b1;
          lose <= full && !pair;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
